// File: rtl/skeleton_cpu.sv
// skeleton_cpu: single-cycle MIPS-style core; every instruction spans four clock phases.
// Define RSTATUS_OVF_EN to report signed overflow of add/addi/sub in R30 instead of writing rd.
module skeleton_cpu #(
    parameter string IMEM_FILE = "imem.mif",
    parameter int    MEM_AW    = 12
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_clock,
    output logic        dmem_clock,
    output logic        processor_clock,
    output logic        regfile_clock,
    output logic [31:0] q,
    output logic [31:0] ALU_reg_imm,
    output logic [31:0] ALU_reg_test
);
    localparam logic [4:0] OP_R = 5'd0, OP_J = 5'd1, OP_BNE = 5'd2, OP_JAL = 5'd3, OP_JR = 5'd4,
        OP_ADDI = 5'd5, OP_BLT = 5'd6, OP_SW = 5'd7, OP_LW = 5'd8, OP_SETX = 5'd21, OP_BEX = 5'd22;

    logic [31:0] imem [1<<MEM_AW];
    logic [31:0] dmem [1<<MEM_AW];
    logic [31:0] regs [32];
    logic [1:0]  ph;
    logic [31:0] pc, pc_next, ld_data, a, b, n, t, sum, diff, wd;
    logic [4:0]  op, rd, rs, rt, shamt, aluop, wa;
    logic        we;

    assign imem_clock = clock;
    assign dmem_clock = clock;
    assign regfile_clock = clock;
    assign processor_clock = ~ph[1];

    assign {op, rd, rs, rt, shamt, aluop} = q[31:2];
    assign n = {{15{q[16]}}, q[16:0]};
    assign t = {5'd0, q[26:0]};
    assign a = regs[rs];
    assign b = ALU_reg_imm;
    assign ALU_reg_test = a;
    assign sum = a + b;
    assign diff = a - b;

    assign ALU_reg_imm = op == OP_R ? regs[rt]
        : (op == OP_ADDI || op == OP_SW || op == OP_LW) ? n
        : (op == OP_BNE || op == OP_BLT || op == OP_JR) ? regs[rd]
        : op == OP_BEX ? regs[30] : 32'd0;

`ifdef RSTATUS_OVF_EN
    logic [31:0] ovf_code;
    assign ovf_code = (op == OP_R && aluop == 5'd0 && a[31] == b[31] && sum[31] != a[31]) ? 32'd1
        : (op == OP_ADDI && a[31] == b[31] && sum[31] != a[31]) ? 32'd2
        : (op == OP_R && aluop == 5'd1 && a[31] != b[31] && diff[31] != a[31]) ? 32'd3 : 32'd0;
`endif

    always_comb begin
        we = 1'b0;
        wa = rd;
        wd = sum;
        pc_next = pc + 32'd1;
        case (op)
            OP_R: begin
                we = aluop <= 5'd5;
                case (aluop)
                    5'd1: wd = diff;
                    5'd2: wd = a & b;
                    5'd3: wd = a | b;
                    5'd4: wd = a << shamt;
                    5'd5: wd = $signed(a) >>> shamt;
                    default: ;
                endcase
            end
            OP_ADDI: we = 1'b1;
            OP_LW: begin we = 1'b1; wd = ld_data; end
            OP_JAL: begin we = 1'b1; wa = 5'd31; wd = pc + 32'd1; pc_next = t; end
            OP_SETX: begin we = 1'b1; wa = 5'd30; wd = t; end
            OP_J: pc_next = t;
            OP_JR: pc_next = b;
            OP_BNE: if (b != a) pc_next = pc + 32'd1 + n;
            OP_BLT: if ($signed(b) < $signed(a)) pc_next = pc + 32'd1 + n;
            OP_BEX: if (b != 32'd0) pc_next = t;
            default: ;
        endcase
`ifdef RSTATUS_OVF_EN
        if (ovf_code != 32'd0) begin
            wa = 5'd30;
            wd = ovf_code;
        end
`endif
    end

    // fetch entering ph1, load entering ph2, commit on the 3->0 edge
    always_ff @(posedge clock) begin
        if (reset) begin
            ph <= 2'd0;
            pc <= 32'd0;
            q <= 32'd0;
            ld_data <= 32'd0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else begin
            ph <= ph + 2'd1;
            if (ph == 2'd0) q <= imem[pc[MEM_AW-1:0]];
            if (ph == 2'd1) ld_data <= dmem[sum[MEM_AW-1:0]];
            if (ph == 2'd3) begin
                pc <= pc_next;
                if (we && wa != 5'd0) regs[wa] <= wd;
            end
        end
    end

    always_ff @(posedge clock)
        if (!reset && ph == 2'd3 && op == OP_SW) dmem[sum[MEM_AW-1:0]] <= regs[rd];
endmodule

// File: tb/tb_skeleton_cpu.sv
// tb_skeleton_cpu: directed program checked against an instruction-level model of the core.
module tb_skeleton_cpu;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic imem_clock, dmem_clock, processor_clock, regfile_clock;
    logic [31:0] q, ALU_reg_imm, ALU_reg_test;
    int total = 0;
    int bad = 0;
    logic [31:0] prog [128];
    logic [31:0] m_r [32];
    logic [31:0] m_dmem [4096];
    int m_pc;
`ifdef RSTATUS_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    skeleton_cpu #(.IMEM_FILE(""), .MEM_AW(12)) dut (
        .clock(clock), .reset(reset), .imem_clock(imem_clock), .dmem_clock(dmem_clock),
        .processor_clock(processor_clock), .regfile_clock(regfile_clock), .q(q),
        .ALU_reg_imm(ALU_reg_imm), .ALU_reg_test(ALU_reg_test)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] it(input int op, input int rd, input int rs, input int imm);
        logic [31:0] w;
        w = {op[4:0], rd[4:0], rs[4:0], imm[16:0]};
        return w;
    endfunction

    function automatic logic [31:0] rt(input int rd, input int rs, input int rt2, input int sh, input int fn);
        logic [31:0] w;
        w = {5'd0, rd[4:0], rs[4:0], rt2[4:0], sh[4:0], fn[4:0], 2'd0};
        return w;
    endfunction

    function automatic logic [31:0] jt(input int op, input int tgt);
        logic [31:0] w;
        w = {op[4:0], tgt[26:0]};
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (model pc %0d): got %h want %h", nm, m_pc, act, exp);
        end
    endtask

    task automatic wr(input int idx, input logic [31:0] v);
        if (idx != 0) m_r[idx] = v;
    endtask

    task automatic arith(input int idx, input longint s, input int code);
        if (OVF && (s > 64'sd2147483647 || s < -64'sd2147483648)) wr(30, code);
        else wr(idx, s[31:0]);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_r[i] = 32'd0;
        m_pc = 0;
    endtask

    // compare one instruction's outputs, then retire it in the model
    task automatic observe();
        logic [31:0] ins, a, b, n, t, nxt, ea;
        int op, rd, rs, rt2, sh, fn;
        longint sa, sb;
        ins = prog[m_pc];
        op = int'(ins[31:27]);
        rd = int'(ins[26:22]);
        rs = int'(ins[21:17]);
        rt2 = int'(ins[16:12]);
        sh = int'(ins[11:7]);
        fn = int'(ins[6:2]);
        n = {{15{ins[16]}}, ins[16:0]};
        t = {5'd0, ins[26:0]};
        a = m_r[rs];
        b = op == 0 ? m_r[rt2] : (op == 5 || op == 7 || op == 8) ? n
            : (op == 2 || op == 6 || op == 4) ? m_r[rd] : op == 22 ? m_r[30] : 32'd0;
        chk("q", q, ins);
        chk("alu_test", ALU_reg_test, a);
        chk("alu_imm", ALU_reg_imm, b);
        case (m_pc)
            2: begin chk("lit_add_rs", ALU_reg_test, 32'd5); chk("lit_add_rt", ALU_reg_imm, 32'd3); end
            3: chk("lit_sum", ALU_reg_test, 32'd8);
            10: chk("lit_sra", ALU_reg_test, 32'hFFFF_FFFC);
            19: begin chk("lit_blt_rs", ALU_reg_test, 32'd345); chk("lit_blt_rd", ALU_reg_imm, 32'd49); end
            25: begin chk("lit_blt2_rs", ALU_reg_test, 32'd49); chk("lit_blt2_rd", ALU_reg_imm, 32'd345); end
            30: chk("lit_lw1", ALU_reg_test, 32'd345);
            31: chk("lit_lw2", ALU_reg_test, 32'd567);
            33: chk("lit_bad_aluop", ALU_reg_test, 32'd0);
            49: chk("lit_r31_ret", ALU_reg_test, 32'd49);
            53: chk("lit_r31", ALU_reg_test, 32'd49);
            62: chk("lit_setx0", ALU_reg_test, 32'd0);
            66: chk("lit_ovf_add", ALU_reg_test, OVF ? 32'd1 : 32'd0);
            67: chk("lit_add_rd", ALU_reg_test, OVF ? 32'd0 : 32'h8000_0000);
            72: chk("lit_ovf_addi", ALU_reg_test, OVF ? 32'd2 : 32'd0);
            73: chk("lit_addi_rd", ALU_reg_test, OVF ? 32'd0 : 32'h8000_0000);
            76: chk("lit_ovf_sub", ALU_reg_test, OVF ? 32'd3 : 32'd0);
            77: chk("lit_sub_rd", ALU_reg_test, OVF ? 32'd0 : 32'h7FFF_FFFF);
            default: ;
        endcase
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ea = a + n;
        nxt = m_pc + 1;
        case (op)
            0: case (fn)
                0: arith(rd, sa + sb, 1);
                1: arith(rd, sa - sb, 3);
                2: wr(rd, a & b);
                3: wr(rd, a | b);
                4: wr(rd, a << sh);
                5: wr(rd, $signed(a) >>> sh);
                default: ;
            endcase
            5: arith(rd, sa + sb, 2);
            7: m_dmem[ea[11:0]] = m_r[rd];
            8: wr(rd, m_dmem[ea[11:0]]);
            1: nxt = t;
            3: begin wr(31, m_pc + 1); nxt = t; end
            4: nxt = m_r[rd];
            2: if (m_r[rd] != a) nxt = m_pc + 1 + n;
            6: if ($signed(m_r[rd]) < $signed(a)) nxt = m_pc + 1 + n;
            21: wr(30, t);
            22: if (m_r[30] != 32'd0) nxt = t;
            default: ;
        endcase
        m_pc = int'(nxt);
    endtask

    // advance to the next processor_clock fall, sampling on clock falling edges
    task automatic next_obs(output bit ok);
        bit prev;
        ok = 1'b0;
        prev = processor_clock;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clock);
            if (prev && !processor_clock) ok = 1'b1;
            prev = processor_clock;
        end
    endtask

    task automatic run(input int cnt);
        bit ok;
        for (int k = 0; k < cnt; k++) begin
            next_obs(ok);
            if (!ok) begin
                total++;
                bad++;
                $display("FAIL timeout: no processor_clock fall, want one within 8 cycles");
                break;
            end
            observe();
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_q"}, q, 32'd0);
        chk({tag, "_test"}, ALU_reg_test, 32'd0);
        chk({tag, "_imm"}, ALU_reg_imm, 32'd0);
        chk({tag, "_pclk"}, {31'd0, processor_clock}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) prog[i] = it(5, 20, 0, 99);
        prog[0] = it(5, 1, 0, 5);       prog[1] = it(5, 2, 0, 3);
        prog[2] = rt(3, 1, 2, 0, 0);    prog[3] = it(5, 3, 3, 0);
        prog[4] = rt(4, 1, 2, 0, 1);    prog[5] = rt(5, 1, 2, 0, 2);
        prog[6] = rt(6, 1, 2, 0, 3);    prog[7] = rt(7, 1, 0, 3, 4);
        prog[8] = it(5, 8, 0, -16);     prog[9] = rt(9, 8, 0, 2, 5);
        prog[10] = it(5, 0, 9, 0);      prog[11] = it(5, 10, 0, 345);
        prog[12] = it(5, 27, 0, 49);    prog[13] = it(5, 11, 0, 567);
        prog[14] = it(2, 1, 2, 4);      prog[19] = it(6, 27, 10, 5);
        prog[25] = it(6, 10, 27, 5);    prog[26] = it(7, 10, 0, 1);
        prog[27] = it(7, 11, 0, 2);     prog[28] = it(8, 12, 0, 1);
        prog[29] = it(8, 13, 0, 2);     prog[30] = it(5, 0, 12, 0);
        prog[31] = it(5, 0, 13, 0);     prog[32] = rt(14, 1, 2, 0, 7);
        prog[33] = it(5, 0, 14, 0);     prog[34] = jt(31, 0);
        prog[35] = jt(1, 48);           prog[48] = jt(3, 53);
        prog[49] = it(5, 0, 31, 0);     prog[50] = jt(1, 56);
        prog[53] = it(5, 0, 31, 0);     prog[54] = it(4, 27, 0, 0);
        prog[56] = jt(21, 3);           prog[57] = jt(22, 60);
        prog[60] = jt(21, 0);           prog[61] = jt(22, 40);
        prog[62] = it(5, 0, 30, 0);     prog[63] = it(5, 15, 0, 1);
        prog[64] = rt(15, 15, 0, 30, 4); prog[65] = rt(16, 15, 15, 0, 0);
        prog[66] = it(5, 0, 30, 0);     prog[67] = it(5, 0, 16, 0);
        prog[68] = rt(17, 15, 0, 1, 4); prog[69] = it(5, 18, 15, -1);
        prog[70] = rt(18, 18, 15, 0, 0); prog[71] = it(5, 19, 18, 1);
        prog[72] = it(5, 0, 30, 0);     prog[73] = it(5, 0, 19, 0);
        prog[74] = it(5, 21, 0, 1);     prog[75] = rt(22, 17, 21, 0, 1);
        prog[76] = it(5, 0, 30, 0);     prog[77] = it(5, 0, 22, 0);
        prog[78] = it(6, 8, 1, 2);      prog[81] = jt(1, 81);
        for (int i = 0; i < 4096; i++) dut.imem[i] = i < 128 ? prog[i] : 32'd0;
        model_reset();
        repeat (3) @(negedge clock);
        chk_reset("rst");
        chk("imem_clock", {31'd0, imem_clock}, {31'd0, clock});
        reset = 1'b0;
        run(57);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk_reset("midrst");
        reset = 1'b0;
        model_reset();
        run(6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/skeleton_cpu.md
# skeleton_cpu

Single-cycle, 32-bit, 32-register MIPS-style processor core with on-chip instruction and data memories and a clock-phase generator. It is the top-level processor block of the design. It derives the memory, register-file and processor clocks from one input clock. For verification it exposes the current instruction word and the two ALU operands.

## Interface
- Parameters
  - IMEM_FILE, "imem.mif": program image loaded into instruction memory.
  - MEM_AW, 12: address width of both memories (4096 words each).
- Ports (the module is named skeleton_cpu)
  - clock  in  1  the single system clock; every register is rising-edge triggered on it.
  - reset  in  1  synchronous, active-high reset, sampled on the rising edge of clock.
  - imem_clock  out  1  equals clock.
  - dmem_clock  out  1  equals clock.
  - processor_clock  out  1  instruction-period marker; its falling edge is the observation point for each instruction.
  - regfile_clock  out  1  equals clock.
  - q  out  32  instruction word currently executing.
  - ALU_reg_imm  out  32  second ALU operand.
  - ALU_reg_test  out  32  first ALU operand; always R[rs].

## Operation
- Instruction fields
  - opcode [31:27], rd [26:22], rs [21:17], rt [16:12], shamt [11:7], aluop [6:2].
  - N = imm[16:0], sign-extended to 32 bits.
  - T = [26:0], zero-extended to 32 bits.
- Register file
  - R0 always reads 0; writes to R0 are ignored.
  - R30 is rstatus; R31 is the link register.
- ALU_reg_imm selection
  - R-type (opcode 00000): R[rt].
  - addi, sw, lw: N.
  - bne, blt, jr: R[rd].
  - bex: R30.
  - All other opcodes: 0.
- R-type instructions, selected by aluop
  - 00000 add, 00001 sub, 00010 and, 00011 or.
  - 00100 sll: R[rs] << shamt.
  - 00101 sra: R[rs] >>> shamt (arithmetic).
  - Undefined aluop: no register write.
- Other instructions, by opcode
  - 00101 addi: R[rd] = R[rs] + N.
  - 00111 sw: dmem[R[rs]+N] = R[rd].
  - 01000 lw: R[rd] = dmem[R[rs]+N].
  - 00001 j: PC = T.
  - 00011 jal: R31 = PC+1, then PC = T.
  - 00100 jr: PC = R[rd].
  - 00010 bne: if R[rd] != R[rs], PC = PC+1+N.
  - 00110 blt: if R[rd] < R[rs] (signed), PC = PC+1+N.
  - 10101 setx: R30 = T.
  - 10110 bex: if R30 != 0, PC = T.
  - Undefined opcode: NOP.
- Arithmetic
  - 32-bit two's complement; sums wrap modulo 2^32.
  - Memory addresses use the low MEM_AW bits of the computed address.
- Sequencing: PC advances by 1 per instruction unless a taken branch or jump overrides it.

## Timing
- Phase counter
  - 2-bit counter ph increments on every clock rising edge and wraps 3→0.
  - One instruction spans exactly 4 clock cycles.
  - processor_clock = (ph==0 || ph==1). It is high in ph0/ph1 and falls on entering ph2.
- Fetch: imem is a synchronous ROM read at the edge entering ph1. q and both ALU operands are stable from ph1 through ph3.
- Load: dmem is read at the edge entering ph2.
- Commit: PC, register-file writes and dmem writes all occur on the edge where ph goes 3→0.
- Reset
  - Reset on any edge forces ph=0, PC=0, all registers 0, q=0, ALU_reg_imm=0, ALU_reg_test=0.
  - Reset therefore holds processor_clock=1.
  - Reset asserted mid-instruction aborts that instruction with no commit.
  - dmem contents are retained.
- After reset is deasserted, the first processor_clock falling edge presents instruction 0.

## Configuration
- RSTATUS_OVF_EN defined
  - Signed overflow sets R30 = 1 for add, 2 for addi, 3 for sub.
  - The overflowing instruction does not write rd.
  - If rd==30, the status value is what R30 receives.
- RSTATUS_OVF_EN undefined: overflow wraps silently and rd is written normally.

## Test plan
- Arithmetic
  - Stimulus: addi $1,$0,5; addi $2,$0,3; add $3,$1,$2; addi $3,$3,0.
  - Required: the last instruction shows ALU_reg_test=8.
  - Required: the add shows operands 5 and 3.
- Branches
  - Stimulus: bne $1,$2,4 at PC 14; blt $27,$10,5 with values 49 and 345.
  - Required: bne jumps to 19; blt is taken.
  - Required: reversed-operand blt falls through.
- Overflow (RSTATUS_OVF_EN defined)
  - Stimulus: add 0x40000000+0x40000000; addi 0x7FFFFFFF+1; sub 0x80000000−1.
  - Required: R30 = 1, 2, 3 respectively; each destination register stays 0.
- Memory: sw 345 to address 1 and 567 to address 2, then lw both → R12=345, R13=567.
- Jumps
  - Stimulus: jal 53 at PC 48.
  - Required: R31=49.
  - Stimulus: jr $27 with R27=49.
  - Required: execution resumes at 49.
- Status
  - Stimulus: bex 60 with R30=3; then setx 0; then bex 40.
  - Required: bex 60 is taken; setx 0 gives R30=0; bex 40 falls through.
- Reset mid-run: assert reset for 2 cycles → q=0, PC restarts at 0, and the first processor_clock fall shows imem[0].
